// File: rtl/ctrl_pkg.sv
// Shared definitions for the sequenced ID-stage control unit.
//   - instruction class (mode) encodings
//   - data-processing opcodes and execute-stage ALU command codes
//   - block-transfer sequencer state type
//   - ctrl_t: the group of ID/EX control bits
//   - decode helpers for the single-cycle classes
package ctrl_pkg;

  // instr[27:26]
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  // instr[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Execute-stage ALU commands
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef enum logic {IDLE, SEQ} seq_state_t;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;

  // Data-processing class. Illegal opcodes return all-zero (NOP).
  function automatic ctrl_t decode_dp(input logic [3:0] op, input logic s_bit);
    ctrl_t c;
    c       = '0;
    c.wb_en = 1'b1;
    c.s     = s_bit;
    case (op)
      OP_MOV:  c.exe_cmd = EXE_MOV;
      OP_MVN:  c.exe_cmd = EXE_MVN;
      OP_ADD:  c.exe_cmd = EXE_ADD;
      OP_ADC:  c.exe_cmd = EXE_ADC;
      OP_SUB:  c.exe_cmd = EXE_SUB;
      OP_SBC:  c.exe_cmd = EXE_SBC;
      OP_AND:  c.exe_cmd = EXE_AND;
      OP_ORR:  c.exe_cmd = EXE_ORR;
      OP_EOR:  c.exe_cmd = EXE_EOR;
      // Compare/test only set flags: force S, suppress write-back
      OP_CMP: begin
        c.exe_cmd = EXE_SUB;
        c.s       = 1'b1;
        c.wb_en   = 1'b0;
      end
      OP_TST: begin
        c.exe_cmd = EXE_AND;
        c.s       = 1'b1;
        c.wb_en   = 1'b0;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Single LDR/STR. Only the add-offset form is legal; l_bit selects load.
  function automatic ctrl_t decode_mem(input logic [3:0] op, input logic l_bit);
    ctrl_t c;
    c = '0;
    if (op == OP_ADD) begin
      c.exe_cmd   = EXE_ADD;
      c.mem_read  = l_bit;
      c.mem_write = !l_bit;
      c.wb_en     = l_bit;
    end
    return c;
  endfunction

endpackage

// File: rtl/lsb_finder.sv
// Lowest-set-bit locator for the block-transfer register list.
//   vec_i      : register list to scan
//   idx_o      : index of the lowest set bit (0 when vec_i is empty)
//   one_left_o : exactly one bit is set
//   any_o      : at least one bit is set
module lsb_finder #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [NUM_REGS-1:0]         vec_i,
  output logic [$clog2(NUM_REGS)-1:0] idx_o,
  output logic                        one_left_o,
  output logic                        any_o
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] rest;

  always_comb begin
    idx_o = '0;
    // Scan downwards so the last hit is the lowest index
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = i[IdxW-1:0];
    end
  end

  // Clearing the lowest set bit leaves nothing iff a single bit was set
  assign rest       = vec_i & (vec_i - 1'b1);
  assign any_o      = |vec_i;
  assign one_left_o = any_o && (rest == '0);

endmodule

// File: rtl/control_unit_seq.sv
// Registered ID-stage control decoder with an LDM/STM micro-op sequencer.
// Decodes data-processing, LDR/STR and B, and expands block transfers into
// one micro-op per listed register. All outputs are registered.
//   clk, rst              : clock, synchronous active-high reset
//   instr_valid           : ID-stage instruction present
//   mode, imm, op_code    : instr[27:26], instr[25], instr[24:21]
//   S_in                  : S bit, or L bit for memory classes
//   reg_list              : LDM/STM register list
//   freeze, flush         : pipeline hold / kill (flush wins)
//   execute_command .. s  : ID/EX control fields
//   dest_reg, addr_offset : block micro-op register and byte offset
//   valid_out             : outputs describe a live operation
//   busy                  : more micro-ops pending, IF/ID must hold
module control_unit_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned EXE_CMD_W = 4,
  parameter int unsigned OFS_W     = $clog2(NUM_REGS) + 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        instr_valid,
  input  logic [1:0]                  mode,
  input  logic                        imm,
  input  logic [3:0]                  op_code,
  input  logic                        S_in,
  input  logic [NUM_REGS-1:0]         reg_list,
  input  logic                        freeze,
  input  logic                        flush,
  output logic [EXE_CMD_W-1:0]        execute_command,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic                        wb_en,
  output logic                        b,
  output logic                        s,
  output logic [$clog2(NUM_REGS)-1:0] dest_reg,
  output logic [OFS_W-1:0]            addr_offset,
  output logic                        valid_out,
  output logic                        busy
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  seq_state_t          state_q, state_d;
  logic [NUM_REGS-1:0] rem_q, rem_d;
  logic [IdxW-1:0]     k_q, k_d;
  logic                l_q, l_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [IdxW-1:0]     dest_q, dest_d;
  logic [OFS_W-1:0]    ofs_q, ofs_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  // One finder serves both the incoming list (IDLE) and the remaining list (SEQ)
  logic [NUM_REGS-1:0] fnd_vec;
  logic [NUM_REGS-1:0] fnd_rest;
  logic [IdxW-1:0]     fnd_idx;
  logic                fnd_one_left;
  logic                fnd_any;

  assign fnd_vec  = (state_q == SEQ) ? rem_q : reg_list;
  assign fnd_rest = fnd_vec & (fnd_vec - 1'b1);

  lsb_finder #(
    .NUM_REGS (NUM_REGS)
  ) u_lsb_finder (
    .vec_i      (fnd_vec),
    .idx_o      (fnd_idx),
    .one_left_o (fnd_one_left),
    .any_o      (fnd_any)
  );

  logic            accept;
  logic            emit;
  logic [IdxW-1:0] emit_k;
  logic            emit_l;

  assign accept = (state_q == IDLE) && instr_valid && !busy_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    k_d     = k_q;
    l_d     = l_q;
    ctrl_d  = ctrl_q;
    dest_d  = dest_q;
    ofs_d   = ofs_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    emit    = 1'b0;
    emit_k  = k_q;
    emit_l  = l_q;

    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
      k_d     = '0;
      l_d     = 1'b0;
      ctrl_d  = '0;
      dest_d  = '0;
      ofs_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else if (!freeze) begin
      ctrl_d  = '0;
      dest_d  = '0;
      ofs_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            case (mode)
              MODE_DP:  ctrl_d = decode_dp(op_code, S_in);
              MODE_MEM: ctrl_d = decode_mem(op_code, S_in);
              MODE_BR: begin
                if (imm) begin
                  ctrl_d.b = 1'b1;
                end else if (fnd_any) begin
                  // First micro-op issues on the accepting edge so block
                  // transfers see the same one-cycle latency as everything else
                  emit   = 1'b1;
                  emit_k = '0;
                  emit_l = S_in;
                end
              end
              default: ctrl_d = '0;
            endcase
            // Every legal single-cycle decode sets at least one control bit
            valid_d = |ctrl_d;
          end
        end
        SEQ: begin
          emit = fnd_any;
          if (!fnd_any) state_d = IDLE;
        end
      endcase

      if (emit) begin
        ctrl_d.exe_cmd   = EXE_ADD;
        ctrl_d.mem_read  = emit_l;
        ctrl_d.mem_write = !emit_l;
        ctrl_d.wb_en     = emit_l;
        dest_d           = fnd_idx;
        ofs_d            = '0;
        ofs_d[IdxW+1:0]  = {emit_k, 2'b00};
        valid_d          = 1'b1;
        busy_d           = !fnd_one_left;
        // rem holds only the registers not yet emitted
        rem_d            = fnd_rest;
        k_d              = emit_k + 1'b1;
        l_d              = emit_l;
        state_d          = fnd_one_left ? IDLE : SEQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      k_q     <= '0;
      l_q     <= 1'b0;
      ctrl_q  <= '0;
      dest_q  <= '0;
      ofs_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      k_q     <= k_d;
      l_q     <= l_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      ofs_q   <= ofs_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Upper command bits are always zero
  always_comb begin
    execute_command      = '0;
    execute_command[3:0] = ctrl_q.exe_cmd;
  end

  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign wb_en       = ctrl_q.wb_en;
  assign b           = ctrl_q.b;
  assign s           = ctrl_q.s;
  assign dest_reg    = dest_q;
  assign addr_offset = ofs_q;
  assign valid_out   = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: decode table, hand-built block-transfer
// corner cases, and randomized traffic against a queue-based model.
module tb_control_unit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [1:0]  mode;
  logic        imm;
  logic [3:0]  op_code;
  logic        S_in;
  logic [15:0] reg_list;
  logic        freeze;
  logic        flush;
  logic [3:0]  execute_command;
  logic        mem_read, mem_write, wb_en, b, s;
  logic [3:0]  dest_reg;
  logic [5:0]  addr_offset;
  logic        valid_out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_unit_seq #(
    .NUM_REGS  (16),
    .EXE_CMD_W (4),
    .OFS_W     (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid     (instr_valid),
    .mode            (mode),
    .imm             (imm),
    .op_code         (op_code),
    .S_in            (S_in),
    .reg_list        (reg_list),
    .freeze          (freeze),
    .flush           (flush),
    .execute_command (execute_command),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .wb_en           (wb_en),
    .b               (b),
    .s               (s),
    .dest_reg        (dest_reg),
    .addr_offset     (addr_offset),
    .valid_out       (valid_out),
    .busy            (busy)
  );

  // Packed view: {exe, mr, mw, wb, b, s, dest, ofs, valid, busy}
  function automatic logic [20:0] mk(int exe, int mr, int mw, int wb, int br, int sb,
                                     int dest, int ofs, int vld, int bsy);
    return {exe[3:0], mr[0], mw[0], wb[0], br[0], sb[0], dest[3:0], ofs[5:0], vld[0], bsy[0]};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {execute_command, mem_read, mem_write, wb_en, b, s, dest_reg, addr_offset,
            valid_out, busy};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] md, input logic im, input logic [3:0] op,
                       input logic sb, input logic [15:0] rl);
    instr_valid = iv;
    mode        = md;
    imm         = im;
    op_code     = op;
    S_in        = sb;
    reg_list    = rl;
  endtask

  task automatic tick_check(input string name, input logic [20:0] exp);
    @(posedge clk);
    #1;
    check(name, dut_vec(), exp);
  endtask

  typedef struct {
    string       name;
    logic        iv;
    logic [1:0]  md;
    logic        im;
    logic [3:0]  op;
    logic        sb;
    logic [15:0] rl;
    logic [20:0] exp;
  } vec_t;

  function automatic vec_t mkv(string name, int iv, int md, int im, int op, int sb, int rl,
                               logic [20:0] exp);
    vec_t v;
    v.name = name;
    v.iv   = iv[0];
    v.md   = md[1:0];
    v.im   = im[0];
    v.op   = op[3:0];
    v.sb   = sb[0];
    v.rl   = rl[15:0];
    v.exp  = exp;
    return v;
  endfunction

  // ---------------- behavioural reference for random traffic ----------------
  logic [20:0] m_out;
  logic [20:0] m_q[$];

  function automatic logic [20:0] ref_single(logic [1:0] md, logic im, logic [3:0] op, logic sb);
    int cmd;
    if (md == 2'b00) begin
      cmd = 0;
      case (op)
        4'hD: cmd = 1;
        4'hF: cmd = 9;
        4'h4: cmd = 2;
        4'h5: cmd = 3;
        4'h2: cmd = 4;
        4'h6: cmd = 5;
        4'h0: cmd = 6;
        4'hC: cmd = 7;
        4'h1: cmd = 8;
        default: cmd = 0;
      endcase
      if (op == 4'hA) return mk(4, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      if (op == 4'h8) return mk(6, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      if (cmd == 0) return '0;
      return mk(cmd, 0, 0, 1, 0, int'(sb), 0, 0, 1, 0);
    end
    if (md == 2'b01) begin
      if (op != 4'h4) return '0;
      return sb ? mk(2, 1, 0, 1, 0, 0, 0, 0, 1, 0) : mk(2, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    end
    if (md == 2'b10 && im) return mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    return '0;
  endfunction

  task automatic pop_microop();
    m_out = m_q.pop_front();
    m_out[0] = (m_q.size() > 0);
  endtask

  task automatic model_step();
    int k;
    if (rst || flush) begin
      m_q.delete();
      m_out = '0;
    end else if (!freeze) begin
      if (m_q.size() > 0) begin
        pop_microop();
      end else if (instr_valid && mode == 2'b10 && !imm) begin
        k = 0;
        for (int i = 0; i < 16; i++) begin
          if (reg_list[i]) begin
            m_q.push_back(mk(2, int'(S_in), int'(!S_in), int'(S_in), 0, 0, i, 4 * k, 1, 0));
            k++;
          end
        end
        if (m_q.size() > 0) pop_microop();
        else m_out = '0;
      end else if (instr_valid) begin
        m_out = ref_single(mode, imm, op_code, S_in);
      end else begin
        m_out = '0;
      end
    end
  endtask

  vec_t tv[$];

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    drive(0, 2'b00, 0, 4'h0, 0, 16'h0);

    // Reset state
    tick_check("reset", '0);
    tick_check("reset_hold", '0);
    rst = 1'b0;

    // ---------------- decode table ----------------
    tv.push_back(mkv("add_s1",   1, 0, 0, 'h4, 1, 0, mk(2, 0, 0, 1, 0, 1, 0, 0, 1, 0)));
    tv.push_back(mkv("mov_s0",   1, 0, 0, 'hD, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0)));
    tv.push_back(mkv("mvn_s1",   1, 0, 0, 'hF, 1, 0, mk(9, 0, 0, 1, 0, 1, 0, 0, 1, 0)));
    tv.push_back(mkv("adc",      1, 0, 0, 'h5, 0, 0, mk(3, 0, 0, 1, 0, 0, 0, 0, 1, 0)));
    tv.push_back(mkv("sub",      1, 0, 0, 'h2, 0, 0, mk(4, 0, 0, 1, 0, 0, 0, 0, 1, 0)));
    tv.push_back(mkv("sbc",      1, 0, 0, 'h6, 1, 0, mk(5, 0, 0, 1, 0, 1, 0, 0, 1, 0)));
    tv.push_back(mkv("and",      1, 0, 0, 'h0, 0, 0, mk(6, 0, 0, 1, 0, 0, 0, 0, 1, 0)));
    tv.push_back(mkv("orr",      1, 0, 0, 'hC, 0, 0, mk(7, 0, 0, 1, 0, 0, 0, 0, 1, 0)));
    tv.push_back(mkv("eor",      1, 0, 0, 'h1, 1, 0, mk(8, 0, 0, 1, 0, 1, 0, 0, 1, 0)));
    tv.push_back(mkv("cmp_s0",   1, 0, 0, 'hA, 0, 0, mk(4, 0, 0, 0, 0, 1, 0, 0, 1, 0)));
    tv.push_back(mkv("mode11",   1, 3, 1, 'h4, 1, 0, '0));
    tv.push_back(mkv("tst",      1, 0, 0, 'h8, 0, 0, mk(6, 0, 0, 0, 0, 1, 0, 0, 1, 0)));
    tv.push_back(mkv("dp_bad",   1, 0, 0, 'h3, 1, 0, '0));
    tv.push_back(mkv("ldr",      1, 1, 0, 'h4, 1, 0, mk(2, 1, 0, 1, 0, 0, 0, 0, 1, 0)));
    tv.push_back(mkv("str",      1, 1, 0, 'h4, 0, 0, mk(2, 0, 1, 0, 0, 0, 0, 0, 1, 0)));
    tv.push_back(mkv("mem_bad",  1, 1, 0, 'h8, 1, 0, '0));
    tv.push_back(mkv("branch",   1, 2, 1, 'h7, 1, 'hFFFF, mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0)));
    tv.push_back(mkv("ldm_one",  1, 2, 0, 'h0, 1, 'h0008, mk(2, 1, 0, 1, 0, 0, 3, 0, 1, 0)));
    tv.push_back(mkv("ldm_empty", 1, 2, 0, 'h0, 1, 'h0000, '0));
    tv.push_back(mkv("no_valid", 0, 0, 0, 'h4, 1, 0, '0));

    foreach (tv[i]) begin
      drive(tv[i].iv, tv[i].md, tv[i].im, tv[i].op, tv[i].sb, tv[i].rl);
      tick_check(tv[i].name, tv[i].exp);
    end

    // ---------------- LDM 0x0013 with ADD waiting behind it ----------------
    drive(1, 2'b10, 0, 4'h0, 1, 16'h0013);
    tick_check("ldm13_op0", mk(2, 1, 0, 1, 0, 0, 0, 0, 1, 1));
    drive(1, 2'b00, 0, 4'h4, 0, 16'h0);
    tick_check("ldm13_op1", mk(2, 1, 0, 1, 0, 0, 1, 4, 1, 1));
    tick_check("ldm13_op2", mk(2, 1, 0, 1, 0, 0, 4, 8, 1, 0));
    tick_check("ldm13_add", mk(2, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    drive(0, 2'b00, 0, 4'h0, 0, 16'h0);
    tick_check("ldm13_idle", '0);

    // ---------------- STM 0x8001 with a two-cycle freeze ----------------
    drive(1, 2'b10, 0, 4'h0, 0, 16'h8001);
    tick_check("stm_op0", mk(2, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    drive(0, 2'b00, 0, 4'h0, 0, 16'h0);
    freeze = 1'b1;
    tick_check("stm_frz1", mk(2, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    tick_check("stm_frz2", mk(2, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    freeze = 1'b0;
    tick_check("stm_op1", mk(2, 0, 1, 0, 0, 0, 15, 4, 1, 0));
    tick_check("stm_done", '0);

    // ---------------- LDM 0x00F0 flushed after the second micro-op ----------------
    drive(1, 2'b10, 0, 4'h0, 1, 16'h00F0);
    tick_check("ldmf0_op0", mk(2, 1, 0, 1, 0, 0, 4, 0, 1, 1));
    drive(0, 2'b00, 0, 4'h0, 0, 16'h0);
    tick_check("ldmf0_op1", mk(2, 1, 0, 1, 0, 0, 5, 4, 1, 1));
    flush = 1'b1;
    tick_check("ldmf0_flush", '0);
    flush = 1'b0;
    tick_check("ldmf0_after1", '0);
    tick_check("ldmf0_after2", '0);

    // ---------------- reset mid-sequence ----------------
    drive(1, 2'b10, 0, 4'h0, 1, 16'h00FF);
    tick_check("rst_seq_op0", mk(2, 1, 0, 1, 0, 0, 0, 0, 1, 1));
    drive(0, 2'b00, 0, 4'h0, 0, 16'h0);
    rst = 1'b1;
    tick_check("rst_seq_rst", '0);
    rst = 1'b0;
    tick_check("rst_seq_after", '0);
    // IDLE after reset: a new instruction is accepted straight away
    drive(1, 2'b00, 0, 4'hD, 1, 16'h0);
    tick_check("rst_seq_mov", mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0));

    // ---------------- flush while frozen, and frozen single-cycle hold ----------------
    drive(1, 2'b00, 0, 4'h4, 1, 16'h0);
    tick_check("frz_add", mk(2, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    drive(1, 2'b00, 0, 4'hD, 0, 16'h0);
    freeze = 1'b1;
    tick_check("frz_hold", mk(2, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    flush = 1'b1;
    tick_check("frz_flush", '0);
    flush = 1'b0;
    freeze = 1'b0;
    drive(0, 2'b00, 0, 4'h0, 0, 16'h0);

    // ---------------- all-ones LDM: offsets 0..60 ----------------
    drive(1, 2'b10, 0, 4'h0, 1, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      tick_check($sformatf("ldm_all_%0d", i), mk(2, 1, 0, 1, 0, 0, i, 4 * i, 1, (i < 15) ? 1 : 0));
      drive(0, 2'b00, 0, 4'h0, 0, 16'h0);
    end

    // ---------------- randomized traffic vs. model ----------------
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        rst    = ($urandom_range(0, 99) == 0);
        freeze = ($urandom_range(0, 9) == 0);
        flush  = ($urandom_range(0, 24) == 0);
        instr_valid = ($urandom_range(0, 4) != 0);
        mode    = 2'($urandom_range(0, 3));
        imm     = 1'($urandom_range(0, 1));
        op_code = ($urandom_range(0, 1) == 0) ? 4'h4 : 4'($urandom_range(0, 15));
        S_in    = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       reg_list = 16'h0;
          1:       reg_list = 16'h1 << $urandom_range(0, 15);
          2:       reg_list = 16'($urandom);
          default: reg_list = 16'($urandom) & 16'($urandom);
        endcase
      end
      @(posedge clk);
      model_step();
      #1;
      check("random", dut_vec(), m_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_seq.md
Name: control_unit_seq

Overview:
- Registered, parametrised successor to the ID-stage control decoder.
- Decodes the ARM data-processing, LDR/STR and B classes, and adds LDM/STM block transfer. Block transfers are expanded into one micro-op per listed register by an internal sequencer.
- Drives the ID/EX control fields directly and honours pipeline freeze and flush.
- Raises busy so the hazard unit holds IF/ID while a block transfer is still expanding.

Parameters:
- NUM_REGS, 16, register-file size; width of reg_list; must be a power of 2 and ≥2.
- EXE_CMD_W, 4, width of execute_command; must be ≥4; upper bits are zero.
- OFS_W, $clog2(NUM_REGS)+2, width of addr_offset (byte offset = 4·k).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  ID-stage instruction present.
- mode  in  2  instr[27:26].
- imm  in  1  instr[25]. With mode 10: 1 = branch, 0 = block transfer.
- op_code  in  4  instr[24:21].
- S_in  in  1  instr[20]: S bit, or L bit for memory classes.
- reg_list  in  NUM_REGS  LDM/STM register list.
- freeze  in  1  hold all state and outputs.
- flush  in  1  kill current output and abort any sequence.
- execute_command  out  EXE_CMD_W  ALU command.
- mem_read, mem_write, wb_en, b, s  out  1 each  control bits.
- dest_reg  out  $clog2(NUM_REGS)  micro-op register index (block ops only, else 0).
- addr_offset  out  OFS_W  byte offset added to base (block ops only, else 0).
- valid_out  out  1  outputs describe a live operation.
- busy  out  1  sequencer has further micro-ops pending; IF/ID must hold.

Behaviour:
- All outputs are registered. Reset value is 0 for every output; state is IDLE; the remaining-list register is 0.
- Priority each edge: rst > flush > freeze > normal.
- Latency: an instruction accepted at edge E has its outputs valid in the cycle following E.
- Acceptance: an instruction is accepted in IDLE when instr_valid=1 and busy=0. Inputs are ignored while busy=1.
- Decode in IDLE for mode 00. In each entry below, s = S_in and wb_en = 1 unless stated:
  - MOV 1101 → 0001
  - MVN 1111 → 1001
  - ADD 0100 → 0010
  - ADC 0101 → 0011
  - SUB 0010 → 0100
  - SBC 0110 → 0101
  - AND 0000 → 0110
  - ORR 1100 → 0111
  - EOR 0001 → 1000
  - CMP 1010 → 0100, s=1, wb_en=0
  - TST 1000 → 0110, s=1, wb_en=0
  - Any other op_code → NOP: all outputs 0, valid_out=0.
- Decode for mode 01:
  - Only op_code 0100 is legal; execute_command = 0010.
  - S_in=1: LDR, mem_read=1, wb_en=1.
  - S_in=0: STR, mem_write=1.
  - Any other op_code → NOP.
- Decode for mode 10:
  - imm=1: branch, b=1, everything else 0, valid_out=1.
  - imm=0: block transfer, described below.
- Decode for mode 11: NOP. This changes the previous decoder, which asserted b for mode 11.
- Block transfer, on acceptance:
  - Empty reg_list → NOP; no busy.
  - Otherwise latch L=S_in and the remaining list, set k=0, and go to SEQ.
- Block transfer, in SEQ on each non-frozen edge:
  - Emit a micro-op for the lowest set bit i of the remaining list: execute_command=0010, dest_reg=i, addr_offset=4k, mem_read=L, mem_write=!L, wb_en=L, s=0, valid_out=1.
  - Clear bit i and increment k.
  - busy=1 while bits remain after the emitted one.
  - Return to IDLE when the emitted bit was the last one.
- Block transfer with n set bits: micro-ops occupy n consecutive unfrozen cycles, and busy is 1 for the first n-1 of them. An all-ones list with NUM_REGS=16 gives offsets 0…60 with no overflow of OFS_W.
- freeze=1: outputs, state, remaining list and k are all held unchanged.
- flush=1: all outputs are cleared to 0 next cycle (valid_out=0, busy=0) and state returns to IDLE. The instruction present that cycle is not accepted. Flush while frozen still flushes.
- rst mid-sequence: everything returns to reset values next cycle; no further micro-ops are emitted.

Decomposition:
- ctrl_pkg holds:
  - the mode constants (DP=00, MEM=01, BR=10);
  - the opcode constants;
  - the EXE_* command constants;
  - typedef enum {IDLE, SEQ} seq_state_t;
  - a packed struct ctrl_t grouping execute_command, mem_read, mem_write, wb_en, b, s.
- Sub-module lsb_finder (parametrised by NUM_REGS): combinational; outputs the index of the lowest set bit, a one_left flag and an any flag.

Test Plan:
- ADD, S_in=1, instr_valid=1 → next cycle: execute_command=0010, wb_en=1, s=1, valid_out=1, busy=0.
- CMP with S_in=0, then mode 11 → CMP cycle: execute_command=0100, s=1, wb_en=0. Mode 11 cycle: all outputs 0, valid_out=0.
- LDM, reg_list=16'h0013, S_in=1:
  - Three cycles with dest_reg 0, 1, 4 and addr_offset 0, 4, 8; mem_read=1 and wb_en=1 throughout; busy 1, 1, 0.
  - A following ADD presented under busy is accepted only after the third micro-op.
- STM, reg_list=16'h8001, freeze=1 for 2 cycles after the first micro-op → dest_reg=0 held for 3 cycles, then dest_reg=15, offset=4, mem_write=1.
- LDM, reg_list=16'h00F0, flush after the second micro-op → next cycle all outputs 0, busy=0; no dest_reg 6 or 7 is ever emitted.
- rst during a sequence, and LDM with reg_list=0 → rst: all outputs 0 next cycle and state IDLE. Empty list: valid_out=0, busy=0.
